// File: rtl/dff_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbitrated flop register.
// Holds the FSM state encoding and the pointer-width helper.
package dff_reg_arbiter_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ENC_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ENC_LOAD = 2'd1;
    localparam logic [STATE_W-1:0] ENC_ACK  = 2'd2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = ENC_IDLE,
        ST_LOAD = ENC_LOAD,
        ST_ACK  = ENC_ACK
    } state_t;

    // Bits needed to index N requesters; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dff_reg_arbiter_if.sv
// Requester-side bus of the shared register: request/data in, grant/ack/status out.
// The arbiter uses the slave modport, client logic uses the master modport.
interface dff_reg_arbiter_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8
);

    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] wdata;
    logic [N-1:0]       grant;
    logic [N-1:0]       ack;
    logic               busy;
    logic [WIDTH-1:0]   Q;
    logic [WIDTH-1:0]   not_Q;

    modport master (
        output req,
        output wdata,
        input  grant,
        input  ack,
        input  busy,
        input  Q,
        input  not_Q
    );

    modport slave (
        input  req,
        input  wdata,
        output grant,
        output ack,
        output busy,
        output Q,
        output not_Q
    );

endinterface

// File: rtl/dff_reg_arbiter_dff_syn_reg.sv
// WIDTH-bit synchronous-reset D flip-flop register with load enable.
// not_Q is the bitwise complement of Q at all times.
module dff_syn_reg #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] not_Q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= RESET_VAL;
        end else if (en) begin
            Q <= D;
        end
    end

    assign not_Q = ~Q;

endmodule

// File: rtl/dff_reg_arbiter.sv
// Round-robin arbiter sharing one flop register among N requesters.
// Each transfer walks IDLE -> LOAD -> ACK -> IDLE; a withdrawn request aborts in LOAD.
module dff_reg_arbiter
    import dff_reg_arbiter_pkg::*;
#(
    parameter int unsigned      N         = 4,
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    dff_reg_arbiter_if.slave    bus
);

    localparam int unsigned   PW   = ptr_width(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_nxt;
    logic [PW-1:0]    winner;
    logic [PW-1:0]    winner_nxt;
    logic [PW-1:0]    pick_c;
    logic             found_c;
    logic [N-1:0]     grant_q;
    logic [N-1:0]     grant_nxt;
    logic [N-1:0]     ack_q;
    logic [N-1:0]     ack_nxt;
    logic             busy_q;
    logic             busy_nxt;
    logic             reg_en_c;
    logic [WIDTH-1:0] ld_data_c;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] not_q_w;

    function automatic logic [N-1:0] onehot(input logic [PW-1:0] idx);
        return N'(1) << idx;
    endfunction

    // Requester index base+off, wrapped modulo N.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base,
                                             input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return PW'(s);
    endfunction

    // First active request at or after ptr, wrapping.
    always_comb begin
        found_c = 1'b0;
        pick_c  = ptr;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found_c && bus.req[rr_idx(ptr, k)]) begin
                found_c = 1'b1;
                pick_c  = rr_idx(ptr, k);
            end
        end
    end

    // Data mux for the current winner.
    always_comb begin
        ld_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner == PW'(i)) begin
                ld_data_c = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            winner  <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            winner  <= winner_nxt;
            grant_q <= grant_nxt;
            ack_q   <= ack_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        winner_nxt = winner;
        grant_nxt  = grant_q;
        ack_nxt    = '0;
        reg_en_c   = 1'b0;

        case (state)
            ST_IDLE: begin
                grant_nxt = '0;
                if (found_c) begin
                    winner_nxt = pick_c;
                    grant_nxt  = onehot(pick_c);
                    state_nxt  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (bus.req[winner]) begin
                    reg_en_c  = 1'b1;
                    ack_nxt   = onehot(winner);
                    state_nxt = ST_ACK;
                end else begin
                    // Withdrawn request: drop the grant, keep ptr so the search restarts from it.
                    grant_nxt = '0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                grant_nxt = '0;
                ptr_nxt   = (winner == LAST) ? '0 : winner + 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    dff_syn_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (reg_en_c),
        .D     (ld_data_c),
        .Q     (q_w),
        .not_Q (not_q_w)
    );

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.Q     = q_w;
    assign bus.not_Q = not_q_w;

endmodule

// File: tb/tb_dff_reg_arbiter.sv
// Bench for dff_reg_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_dff_reg_arbiter;

    localparam int unsigned      N         = 4;
    localparam int unsigned      WIDTH     = 8;
    localparam logic [WIDTH-1:0] RESET_VAL = 8'h00;

    logic clk = 1'b0;
    logic reset;

    dff_reg_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    dff_reg_arbiter #(
        .N         (N),
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int ack_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is "pick winner, then commit or abort, then advance pointer".
    int               m_phase;
    int               m_win;
    int               m_ptr;
    int               m_pick;
    logic [WIDTH-1:0] m_q;
    logic [N-1:0]     m_grant;
    logic [N-1:0]     m_ack;

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int d = 0; d < int'(N); d++) begin
            if (r[(p + d) % int'(N)]) return (p + d) % int'(N);
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_ptr   = 0;
            m_win   = 0;
            m_q     = RESET_VAL;
            m_grant = '0;
            m_ack   = '0;
        end else begin
            case (m_phase)
                0: begin
                    m_pick = model_pick(bus.req, m_ptr);
                    m_ack  = '0;
                    if (m_pick >= 0) begin
                        m_win   = m_pick;
                        m_grant = N'(1) << m_win;
                        m_phase = 1;
                    end else begin
                        m_grant = '0;
                    end
                end
                1: begin
                    if (bus.req[m_win]) begin
                        m_q     = bus.wdata[m_win*WIDTH +: WIDTH];
                        m_ack   = N'(1) << m_win;
                        m_phase = 2;
                    end else begin
                        m_grant = '0;
                        m_phase = 0;
                    end
                end
                default: begin
                    m_ack   = '0;
                    m_grant = '0;
                    m_ptr   = (m_win + 1) % int'(N);
                    m_phase = 0;
                end
            endcase
        end
    end

    // Every-cycle comparison against the model, plus a log of acknowledged requesters.
    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", bus.grant, m_grant);
            check("ack", bus.ack, m_ack);
            check("busy", bus.busy, m_phase != 0);
            check("Q", bus.Q, m_q);
            check("not_Q", bus.not_Q, {~m_q});
            for (int i = 0; i < int'(N); i++) begin
                if (bus.ack[i]) ack_log.push_back(i);
            end
        end
    end

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    // Requesters drop req once acked; bounded wait for the bus to drain.
    task automatic run_until_idle(input int max, input string name);
        int c;
        c = 0;
        while ((bus.req != '0 || bus.busy) && c < max) begin
            nedge();
            bus.req = bus.req & ~bus.ack;
            c++;
        end
        check({name, "_drain"}, c < max, 1);
    endtask

    initial begin
        int c;
        int cnt[N];

        reset     = 1'b1;
        bus.req   = '0;
        bus.wdata = '0;

        // Reset with all requests active
        bus.req = 4'b1111;
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        nedge();
        check("rst_grant", bus.grant, 0);
        check("rst_ack", bus.ack, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_q", bus.Q, 8'h00);
        check("rst_nq", bus.not_Q, 8'hFF);
        bus.req = '0;
        reset   = 1'b0;

        // Single request timing
        nedge();
        bus.req = 4'b0100;
        bus.wdata[2*WIDTH +: WIDTH] = 8'hA5;
        nedge();
        check("single_grant", bus.grant, 4'b0100);
        check("single_ack_early", bus.ack, 0);
        nedge();
        check("single_q", bus.Q, 8'hA5);
        check("single_nq", bus.not_Q, 8'h5A);
        check("single_ack", bus.ack, 4'b0100);
        bus.req = '0;
        nedge();
        check("single_idle_grant", bus.grant, 0);
        check("single_idle_ack", bus.ack, 0);
        check("single_idle_busy", bus.busy, 0);

        // All requesting from ptr=0
        reset = 1'b1;
        nedge();
        reset = 1'b0;
        for (int i = 0; i < int'(N); i++) bus.wdata[i*WIDTH +: WIDTH] = 8'(8'hC0 + i);
        ack_log.delete();
        bus.req = 4'b1111;
        run_until_idle(100, "all");
        check("all_count", ack_log.size(), 4);
        for (int j = 0; j < 4; j++) begin
            if (j < ack_log.size()) check("all_order", ack_log[j], j);
        end

        // Pointer wrap: after winner 3, requester 0 wins over 3
        bus.req = 4'b1001;
        nedge();
        check("wrap_grant", bus.grant, 4'b0001);
        run_until_idle(100, "wrap");
        check("wrap_q", bus.Q, 8'hC3);

        // Withdraw before the LOAD edge
        bus.req = 4'b0010;
        nedge();
        check("wd_grant", bus.grant, 4'b0010);
        bus.req = '0;
        nedge();
        check("wd_grant_off", bus.grant, 0);
        check("wd_ack", bus.ack, 0);
        check("wd_busy", bus.busy, 0);
        check("wd_q", bus.Q, 8'hC3);
        bus.req = 4'b1010;
        nedge();
        check("wd_next", bus.grant, 4'b0010);
        run_until_idle(100, "wd");

        // Reset during LOAD, with ptr moved to 3 beforehand
        bus.req = 4'b0100;
        run_until_idle(100, "pre_rst");
        bus.req = 4'b0001;
        nedge();
        check("mid_grant", bus.grant, 4'b0001);
        reset = 1'b1;
        nedge();
        check("mid_q", bus.Q, RESET_VAL);
        check("mid_grant_off", bus.grant, 0);
        check("mid_ack", bus.ack, 0);
        check("mid_busy", bus.busy, 0);
        reset   = 1'b0;
        bus.req = 4'b1001;
        nedge();
        check("mid_ptr", bus.grant, 4'b0001);
        run_until_idle(100, "mid");

        // Fairness with all requests held for 20 transfers
        ack_log.delete();
        bus.req = 4'b1111;
        c = 0;
        while (ack_log.size() < 20 && c < 200) begin
            nedge();
            c++;
        end
        check("fair_done", c < 200, 1);
        for (int i = 0; i < int'(N); i++) cnt[i] = 0;
        for (int j = 0; j < ack_log.size(); j++) begin
            cnt[ack_log[j]]++;
            if (j > 0) check("fair_rr", ack_log[j], (ack_log[0] + j) % int'(N));
        end
        for (int i = 0; i < int'(N); i++) check("fair_cnt", cnt[i], ack_log.size() / int'(N));
        bus.req = '0;
        run_until_idle(20, "fair");

        // Random traffic including occasional withdrawals
        for (int cyc = 0; cyc < 2000; cyc++) begin
            nedge();
            for (int i = 0; i < int'(N); i++) begin
                if (bus.req[i] && bus.ack[i]) begin
                    bus.req[i] = 1'b0;
                end else if (bus.req[i] && bus.grant[i] && $urandom_range(15) == 0) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(2) == 0) begin
                    bus.wdata[i*WIDTH +: WIDTH] = 8'($urandom);
                    bus.req[i] = 1'b1;
                end
            end
        end
        run_until_idle(100, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
